// File: rtl/vedic_dot_acc.sv
// Streaming unsigned 8x8 dot-product accumulator built on a Vedic (Urdhva-Tiryagbhyam) multiplier.
// A run of len operand pairs is accumulated modulo 2^ACC_W with a sticky carry-out flag.

module vedic2x2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] p
);
    logic c;
    assign p[0] = a[0] & b[0];
    assign p[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
    assign c    = (a[1] & b[0]) & (a[0] & b[1]);
    assign p[2] = (a[1] & b[1]) ^ c;
    assign p[3] = (a[1] & b[1]) & c;
endmodule

module vedic4x4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    logic [3:0] q0, q1, q2, q3;
    logic [4:0] mid;
    vedic2x2 u_q0 (.a(a[1:0]), .b(b[1:0]), .p(q0));
    vedic2x2 u_q1 (.a(a[3:2]), .b(b[1:0]), .p(q1));
    vedic2x2 u_q2 (.a(a[1:0]), .b(b[3:2]), .p(q2));
    vedic2x2 u_q3 (.a(a[3:2]), .b(b[3:2]), .p(q3));
    // Cross products share the same weight, so they are summed before shifting.
    assign mid = {1'b0, q1} + {1'b0, q2};
    assign p   = {q3, 4'b0} + {1'b0, mid, 2'b0} + {4'b0, q0};
endmodule

module vedic8x8 (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] prod
);
    logic [7:0] q0, q1, q2, q3;
    logic [8:0] mid;
    vedic4x4 u_q0 (.a(a[3:0]), .b(b[3:0]), .p(q0));
    vedic4x4 u_q1 (.a(a[7:4]), .b(b[3:0]), .p(q1));
    vedic4x4 u_q2 (.a(a[3:0]), .b(b[7:4]), .p(q2));
    vedic4x4 u_q3 (.a(a[7:4]), .b(b[7:4]), .p(q3));
    assign mid  = {1'b0, q1} + {1'b0, q2};
    assign prod = {q3, 8'b0} + {3'b0, mid, 4'b0} + {8'b0, q0};
endmodule

module vedic_dot_acc #(
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] sum,
    output logic             ovf,
    output logic             busy,
    output logic [1:0]       dbg_state
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [ACC_W-1:0]   acc;
    logic               ovf_acc;
    logic [7:0]         remaining;
    logic [15:0]        prod;
    logic [ACC_W:0]     acc_ext;
    logic               accept;
    logic               last_pair;

    vedic8x8 u_mul (.a(a), .b(b), .prod(prod));

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid never depends on ready, and the producer holds its data until the transfer.
    assign accept    = in_valid && in_ready;
    assign last_pair = (remaining == 8'd1);
    assign acc_ext   = {1'b0, acc} + {{(ACC_W-15){1'b0}}, prod};
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = (len == 8'd0) ? DONE : ACCUM;
            end
            ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (accept && last_pair) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The result registers load only when a run completes, so sum/ovf hold elsewhere.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            ovf_acc   <= 1'b0;
            remaining <= 8'd0;
            sum       <= '0;
            ovf       <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                acc       <= '0;
                ovf_acc   <= 1'b0;
                remaining <= len;
                if (len == 8'd0) begin
                    sum <= '0;
                    ovf <= 1'b0;
                end
            end
            if (accept) begin
                acc       <= acc_ext[ACC_W-1:0];
                ovf_acc   <= ovf_acc | acc_ext[ACC_W];
                remaining <= remaining - 8'd1;
                if (last_pair) begin
                    sum <= acc_ext[ACC_W-1:0];
                    ovf <= ovf_acc | acc_ext[ACC_W];
                end
            end
        end
    end
endmodule

// File: tb/tb_vedic_dot_acc.sv
// Directed and random bench for vedic_dot_acc; two instances (24- and 16-bit) share stimulus.

module tb_vedic_dot_acc;
    localparam int W = 42;

    typedef struct {
        int              len;
        logic [3:0][7:0] va;
        logic [3:0][7:0] vb;
        int              gap;
        int              stall;
        logic [23:0]     sum24;
        logic            ovf24;
        logic [15:0]     sum16;
        logic            ovf16;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, start, in_valid, out_ready;
    logic [7:0]  len, a, b;
    logic        in_ready24, out_valid24, ovf24, busy24;
    logic        in_ready16, out_valid16, ovf16, busy16;
    logic [23:0] sum24;
    logic [15:0] sum16;
    logic [1:0]  st24, st16;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_q[$];
    vec_t vecs[8];

    vedic_dot_acc #(.ACC_W(24)) dut24 (
        .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid),
        .in_ready(in_ready24), .a(a), .b(b), .out_valid(out_valid24),
        .out_ready(out_ready), .sum(sum24), .ovf(ovf24), .busy(busy24), .dbg_state(st24)
    );

    vedic_dot_acc #(.ACC_W(16)) dut16 (
        .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid),
        .in_ready(in_ready16), .a(a), .b(b), .out_valid(out_valid16),
        .out_ready(out_ready), .sum(sum16), .ovf(ovf16), .busy(busy16), .dbg_state(st16)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic vec_t mk(input int n, input int a0, b0, a1, b1, a2, b2, a3, b3,
                                input int gap, stall, s24, o24, s16, o16);
        vec_t v;
        v.len = n;
        v.va[0] = a0[7:0]; v.vb[0] = b0[7:0];
        v.va[1] = a1[7:0]; v.vb[1] = b1[7:0];
        v.va[2] = a2[7:0]; v.vb[2] = b2[7:0];
        v.va[3] = a3[7:0]; v.vb[3] = b3[7:0];
        v.gap = gap; v.stall = stall;
        v.sum24 = s24[23:0]; v.ovf24 = o24[0];
        v.sum16 = s16[15:0]; v.ovf16 = o16[0];
        return v;
    endfunction

    // reference model for the random runs: true sum reduced to each width
    task automatic push_model(input longint total);
        logic [63:0] t;
        t = total;
        exp_q.push_back({(total >= 64'd65536), t[15:0], (total >= 64'd16777216), t[23:0]});
    endtask

    task automatic do_start(input int n);
        start = 1'b1;
        len   = n[7:0];
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_in_ready", in_ready24, (n != 0));
        chk("start_out_valid", out_valid24, (n == 0));
        chk("start_busy", busy24, 1);
    endtask

    task automatic send_pair(input logic [7:0] x, input logic [7:0] y, input int gap);
        logic rdy, got;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            a = 8'($urandom);
            b = 8'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        a = x;
        b = y;
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            rdy = in_ready24;
            @(posedge clk); #1;
            got = rdy;
        end
        in_valid = 1'b0;
        if (!got) chk("accept_timeout", got, 1);
    endtask

    task automatic collect(input int stall, input bit poke_start);
        logic [W-1:0] e;
        chk("exp_q_nonempty", (exp_q.size() != 0), 1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        chk("out_valid_latency24", out_valid24, 1);
        chk("out_valid_latency16", out_valid16, 1);
        chk("sum24", sum24, e[23:0]);
        chk("ovf24", ovf24, e[24]);
        chk("sum16", sum16, e[40:25]);
        chk("ovf16", ovf16, e[41]);
        for (int k = 0; k < stall; k++) begin
            out_ready = 1'b0;
            start     = poke_start && (k == 1);
            len       = 8'd5;
            @(posedge clk); #1;
            chk("stall_out_valid", out_valid24, 1);
            chk("stall_sum24", sum24, e[23:0]);
            chk("stall_ovf16", ovf16, e[41]);
            chk("stall_in_ready", in_ready24, 0);
        end
        out_ready = 1'b1;
        start     = 1'b1;
        len       = 8'd3;
        @(posedge clk); #1;
        out_ready = 1'b0;
        start     = 1'b0;
        chk("hs_out_valid_drop", out_valid24, 0);
        chk("hs_busy", busy24, 0);
        chk("hs_state_idle", st24, 2'd0);
    endtask

    initial begin
        vecs[0] = mk(3, 2, 3, 4, 5, 255, 255, 0, 0, 0, 0, 65051, 0, 65051, 0);
        vecs[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0);
        vecs[2] = mk(2, 255, 255, 255, 255, 0, 0, 0, 0, 1, 1, 130050, 0, 64514, 1);
        vecs[3] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[4] = mk(4, 255, 255, 255, 255, 255, 255, 1, 1, 0, 1, 195076, 0, 64004, 1);
        vecs[5] = mk(2, 6, 7, 8, 9, 0, 0, 0, 0, 3, 5, 114, 0, 114, 0);
        vecs[6] = mk(1, 7, 9, 0, 0, 0, 0, 0, 0, 2, 0, 63, 0, 63, 0);
        vecs[7] = mk(3, 16, 16, 0, 200, 100, 3, 0, 0, 1, 3, 556, 0, 556, 0);

        rst = 1'b1; start = 1'b0; len = 8'd0; in_valid = 1'b0;
        out_ready = 1'b0; a = 8'd0; b = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_state", st24, 2'd0);
        chk("rst_out_valid", out_valid24, 0);
        chk("rst_in_ready", in_ready24, 0);
        chk("rst_busy", busy24, 0);
        chk("rst_sum24", sum24, 0);
        chk("rst_ovf24", ovf24, 0);
        chk("rst_sum16", sum16, 0);
        @(posedge clk); #1;
        chk("idle_in_ready", in_ready16, 0);

        // table-driven directed runs
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({vecs[i].ovf16, vecs[i].sum16, vecs[i].ovf24, vecs[i].sum24});
            do_start(vecs[i].len);
            for (int j = 0; j < vecs[i].len; j++)
                send_pair(vecs[i].va[j], vecs[i].vb[j], vecs[i].gap);
            collect(vecs[i].stall, (i == 5));
        end

        // reset mid-run, with start and an operand offered in the same cycle
        do_start(4);
        send_pair(8'd3, 8'd3, 0);
        rst = 1'b1; start = 1'b1; len = 8'd0; in_valid = 1'b1; a = 8'd1; b = 8'd1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; in_valid = 1'b0;
        chk("midrst_state", st24, 2'd0);
        chk("midrst_out_valid", out_valid24, 0);
        chk("midrst_busy", busy24, 0);
        chk("midrst_in_ready", in_ready24, 0);
        exp_q.push_back({1'b0, 16'd63, 1'b0, 24'd63});
        do_start(1);
        send_pair(8'd7, 8'd9, 0);
        collect(0, 1'b0);

        // reset while a result is pending
        exp_q.push_back({1'b0, 16'd0, 1'b0, 24'd0});
        do_start(0);
        rst = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b0;
        chk("donerst_out_valid", out_valid24, 0);
        chk("donerst_state", st16, 2'd0);
        void'(exp_q.pop_front());

        // random runs against the model
        for (int r = 0; r < 200; r++) begin
            int n;
            longint total;
            logic [7:0] x, y;
            n = $urandom_range(1, 255);
            total = 0;
            do_start(n);
            for (int j = 0; j < n; j++) begin
                x = 8'($urandom);
                y = 8'($urandom);
                if ($urandom_range(0, 7) == 0) x = 8'd255;
                if ($urandom_range(0, 7) == 0) y = 8'd255;
                total += longint'(x) * longint'(y);
                send_pair(x, y, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
            end
            push_model(total);
            collect($urandom_range(0, 3), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vedic_dot_acc.md
VEDIC_DOT_ACC -- requirements
Module: vedic_dot_acc

Interface
REQ-001 SHALL have parameter ACC_W, default 24, giving the accumulator and result width; legal range 16..32.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: begins a run; sampled only in IDLE.
REQ-005 SHALL have port len, input, 8 bits: number of operand pairs in the run; latched when start is accepted.
REQ-006 SHALL have port in_valid, input, 1 bit: the a/b operand pair is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts an operand pair.
REQ-008 SHALL have ports a and b, input, 8 bits each: unsigned operands.
REQ-009 SHALL have port out_valid, output, 1 bit: sum and ovf are valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 SHALL have port sum, output, ACC_W bits: unsigned dot product, modulo 2^ACC_W.
REQ-012 SHALL have port ovf, output, 1 bit: a carry out of ACC_W occurred during the run.
REQ-013 SHALL have port busy, output, 1 bit: high in ACCUM and DONE.

Function
REQ-014 SHALL form each product with one instance of the team's vedic8x8 multiplier (a, b -> 16-bit prod), used combinationally.
REQ-015 SHALL implement exactly three states: IDLE, ACCUM and DONE.
REQ-016 SHALL transition on start in IDLE as follows:
- latch len; clear the accumulator and ovf;
- if len==0, go to DONE with sum=0;
- otherwise, go to ACCUM.
REQ-017 SHALL ignore start in ACCUM and DONE, including a start in the same cycle as an output handshake.
REQ-018 SHALL drive in_ready=1 only in ACCUM; in_ready SHALL be 0 in IDLE and DONE.
REQ-019 SHALL count a pair only on a cycle where in_valid and in_ready are both high; on that edge, acc <= acc + zero-extended(a*b), and the remaining count decrements.
REQ-020 SHALL ignore cycles in ACCUM with in_valid=0; they SHALL change no state.
REQ-021 SHALL move to DONE on the edge that accepts the last pair; out_valid SHALL rise the next cycle, and sum SHALL include that last product (latency: 1 cycle from the last accept).
REQ-022 SHALL wrap the accumulator modulo 2^ACC_W; ovf SHALL be set sticky on any carry out of bit ACC_W-1 and SHALL clear only on a new start or on reset.
REQ-023 SHALL hold out_valid=1 in DONE, with sum and ovf stable until out_ready=1.
REQ-024 SHALL return to IDLE on the edge where out_valid and out_ready are both high; out_valid SHALL be 0 the next cycle.
REQ-025 SHALL hold sum and ovf at their last values outside DONE; they are meaningful only while out_valid=1.
REQ-026 SHALL accept zero operands normally: such a pair counts as a pair and contributes 0.

Reset
REQ-027 SHALL, while rst=1 at a rising clk edge, set: state=IDLE, accumulator=0, remaining count=0, sum=0, ovf=0, out_valid=0, in_ready=0, busy=0.
REQ-028 SHALL give rst priority over start and over both handshakes in the same cycle.
REQ-029 SHALL, on reset mid-run (ACCUM or DONE), discard the partial or pending result with no output handshake.

Verification
REQ-030 Basic run: start, len=3, pairs (2,3), (4,5), (255,255) -> sum=65051, ovf=0, out_valid 1 cycle after the third accept.
REQ-031 Empty run: start, len=0 -> out_valid next cycle, sum=0, ovf=0, and no in_ready pulse.
REQ-032 Wrap: ACC_W=16, len=2, pairs (255,255) twice -> sum=64514, ovf=1.
REQ-033 Stalls:
- len=2, in_valid low for 3 cycles between pairs (6,7), (8,9) -> sum=114;
- then out_ready low for 5 cycles -> sum, out_valid stable; in_ready=0; a start pulse during the stall is ignored.
REQ-034 Reset mid-run: len=4, one pair accepted, rst for 1 cycle -> next cycle IDLE, out_valid=0, busy=0; new run len=1, pair (7,9) -> sum=63, ovf=0.
REQ-035 Random run: 200 runs with random len in 1..255 and random in_valid/out_ready gaps -> every sum and ovf matches a reference model.
